clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 104 ++++++++++
 tb/tb_clk_period_meter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an asynchronous divided clock in reference-clock cycles
module clk_period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout,
  output logic             overrun
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic             s1_q, s2_q, s3_q;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] last_p_q, last_p_d;
  logic             prev_q, prev_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             rise, measuring, capture, expire, load;
  assign rise      = s2_q & ~s3_q;
  assign measuring = state_q == MEASURE;
  assign capture   = measuring & rise;
  assign expire    = measuring & ~rise & (cnt_q == CNT_MAX);
  assign load      = capture & (~valid_q | meas_ready);
  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;
  assign overrun    = overrun_q;
  // synchronize sig_in and keep one extra stage for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end
  // fsm and period/high counters: a rise always restarts counting at 1
  always_comb begin
    state_d = !measuring ? (rise ? MEASURE : IDLE) : (expire ? IDLE : MEASURE);
    cnt_d   = rise ? ONE : expire ? '0 : measuring ? cnt_q + ONE : cnt_q;
    hcnt_d  = rise ? ONE : expire ? '0 : measuring ? hcnt_q + CNT_W'(s2_q) : hcnt_q;
  end
  // lock tracking sees every capture, including those dropped at the output
  always_comb begin
    last_p_d  = capture ? cnt_q : last_p_q;
    prev_d    = capture ? 1'b1 : expire ? 1'b0 : prev_q;
    locked_d  = capture ? (prev_q & (cnt_q == last_p_q)) : expire ? 1'b0 : locked_q;
    timeout_d = expire;
  end
  // output holding register with valid/ready handshake and sticky drop flag
  always_comb begin
    period_d  = load ? cnt_q : period_q;
    high_d    = load ? hcnt_q : high_q;
    valid_d   = load ? 1'b1 : (valid_q & meas_ready) ? 1'b0 : valid_q;
    overrun_d = overrun_q | (capture & ~load);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      last_p_q  <= '0;
      prev_q    <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      last_p_q  <= last_p_d;
      prev_q    <= prev_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed checks of period/high-time capture, handshake, lock, timeout and reset
module tb_clk_period_meter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig_in = 1'b0;
  logic        meas_ready = 1'b0;
  logic [15:0] period, high_time;
  logic        meas_valid, locked, timeout, overrun;
  logic [3:0]  period4, high4;
  logic        valid4, locked4, timeout4, overrun4;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nval = 0, nto = 0, got_p = 0, got_h = 0, got_l = 0;
  int nval4 = 0, nto4 = 0, p4 = 0, h4 = 0, cap4_cyc = 0, to4_cyc = 0;
  int b, t, b4, t4;
  clk_period_meter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .meas_ready(meas_ready),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .locked(locked), .timeout(timeout), .overrun(overrun)
  );
  clk_period_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .meas_ready(meas_ready),
    .period(period4), .high_time(high4), .meas_valid(valid4),
    .locked(locked4), .timeout(timeout4), .overrun(overrun4)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (meas_valid && meas_ready) begin
      nval++;
      got_p = int'(period);
      got_h = int'(high_time);
      got_l = int'(locked);
    end
    if (timeout) nto++;
    if (valid4 && meas_ready) begin
      nval4++;
      p4 = int'(period4);
      h4 = int'(high4);
      cap4_cyc = cyc;
    end
    if (timeout4) begin
      nto4++;
      to4_cyc = cyc;
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      tick(hi);
      sig_in = 1'b0;
      tick(lo);
    end
  endtask
  task automatic do_reset();
    sig_in = 1'b0;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
  endtask
  initial begin
    tick(3);
    check("rst_period", int'(period), 0);
    check("rst_high", int'(high_time), 0);
    check("rst_valid", int'(meas_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_valid4", int'(valid4), 0);
    rst = 1'b1;
    meas_ready = 1'b1;
    tick(20);
    check("idle_quiet_valid", int'(meas_valid), 0);
    check("idle_quiet_to", nto, 0);
    // toggling every cycle: period 2
    do_reset();
    b = nval; t = nto;
    wave(1, 1, 10);
    tick(5);
    check("div2_count", nval - b, 9);
    check("div2_period", got_p, 2);
    check("div2_high", got_h, 1);
    check("div2_locked", got_l, 1);
    check("div2_timeout", nto - t, 0);
    // toggling every 10 cycles: period 20
    do_reset();
    b = nval; t = nto;
    wave(10, 10, 5);
    tick(5);
    check("p20_count", nval - b, 4);
    check("p20_period", got_p, 20);
    check("p20_high", got_h, 10);
    check("p20_locked", got_l, 1);
    check("p20_timeout", nto - t, 0);
    check("p20_overrun", int'(overrun), 0);
    // 30 high / 10 low with consumer stalled
    do_reset();
    meas_ready = 1'b0;
    wave(30, 10, 2);
    check("stall1_valid", int'(meas_valid), 1);
    check("stall1_period", int'(period), 40);
    check("stall1_high", int'(high_time), 30);
    check("stall1_overrun", int'(overrun), 0);
    check("stall1_locked", int'(locked), 0);
    wave(30, 10, 1);
    check("stall2_valid", int'(meas_valid), 1);
    check("stall2_period", int'(period), 40);
    check("stall2_high", int'(high_time), 30);
    check("stall2_overrun", int'(overrun), 1);
    check("stall2_locked", int'(locked), 1);
    meas_ready = 1'b1;
    tick(1);
    check("drain_valid", int'(meas_valid), 0);
    check("drain_overrun", int'(overrun), 1);
    check("drain_period", int'(period), 40);
    // CNT_W=4: longest period 15 captures without timeout
    do_reset();
    b4 = nval4; t4 = nto4;
    wave(8, 7, 3);
    check("max_count4", nval4 - b4, 2);
    check("max_period4", p4, 15);
    check("max_high4", h4, 8);
    check("max_timeout4", nto4 - t4, 0);
    check("max_locked4", int'(locked4), 1);
    // CNT_W=4: signal stops, timeout 15 cycles after last capture
    do_reset();
    b4 = nval4; t4 = nto4;
    wave(3, 3, 4);
    check("to_count4", nval4 - b4, 3);
    check("to_period4", p4, 6);
    check("to_high4", h4, 3);
    check("to_prelock4", int'(locked4), 1);
    check("to_early4", nto4 - t4, 0);
    tick(30);
    check("to_pulses4", nto4 - t4, 1);
    check("to_delay4", to4_cyc - cap4_cyc, 15);
    check("to_locked4", int'(locked4), 0);
    check("to_valid4", int'(valid4), 0);
    b4 = nval4;
    wave(3, 3, 1);
    tick(8);
    check("to_rearm4", nval4 - b4, 0);
    // reset pulse mid-period
    do_reset();
    wave(10, 10, 2);
    sig_in = 1'b1;
    tick(10);
    sig_in = 1'b0;
    tick(5);
    check("mid_pre_period", int'(period), 20);
    rst = 1'b0;
    tick(1);
    check("mid_period", int'(period), 0);
    check("mid_high", int'(high_time), 0);
    check("mid_valid", int'(meas_valid), 0);
    check("mid_locked", int'(locked), 0);
    check("mid_timeout", int'(timeout), 0);
    check("mid_overrun", int'(overrun), 0);
    rst = 1'b1;
    b = nval;
    tick(5);
    wave(10, 10, 2);
    tick(5);
    check("post_count", nval - b, 1);
    check("post_period", got_p, 20);
    check("post_high", got_h, 10);
    check("post_locked", got_l, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
